// File: rtl/triangle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : triangle_pkg
//  Description : Shared types and constants for the triangle-wave sequencer
//                (FSM state encoding, default widths, reset values).
//  Revision    : 1.0 - initial release
// ============================================================================
package triangle_pkg;

  // Default datapath widths
  localparam int c_def_width = 8;
  localparam int c_def_cnt_w = 8;

  // Sequencer states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Reset values of the sequencer state and 1-bit status outputs
  localparam state_t c_rst_state = ST_IDLE;
  localparam logic   c_rst_flag  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/triangle_core.sv
`default_nettype none
// ============================================================================
//  Module      : triangle_core
//  Description : Up/down triangle generator. Climbs by step until it reaches
//                peak, then descends by step to 0. wrap strobes on the edge
//                that returns the wave to 0 (one period complete).
//  Revision    : 1.0 - initial release
// ============================================================================
module triangle_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] peak,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] triangle,
  output logic             count_down,
  output logic             wrap
);

  logic [WIDTH-1:0] r_triangle;
  logic             r_count_down;
  logic [WIDTH:0]   w_sum;
  logic             w_bottom;

  // One extra bit so the ascending sum cannot overflow before the peak compare
  assign w_sum    = {1'b0, r_triangle} + {1'b0, step};
  assign w_bottom = (r_triangle <= step);
  // Period completes on the descending step that lands on 0
  assign wrap     = en && !clear && r_count_down && w_bottom;

  assign triangle   = r_triangle;
  assign count_down = r_count_down;

  // Triangle sample and direction update; clear has priority over stepping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_triangle   <= '0;
      r_count_down <= 1'b0;
    end else if (clear) begin
      r_triangle   <= '0;
      r_count_down <= 1'b0;
    end else if (en) begin
      if (!r_count_down) begin
        if (w_sum >= {1'b0, peak}) begin
          r_triangle   <= peak;
          r_count_down <= 1'b1;
        end else begin
          r_triangle <= w_sum[WIDTH-1:0];
        end
      end else begin
        if (w_bottom) begin
          r_triangle   <= '0;
          r_count_down <= 1'b0;
        end else begin
          r_triangle <= r_triangle - step;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/triangle_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : triangle_seq_ctrl
//  Description : Command-driven sequencer that runs the triangle generator for
//                a bounded number of periods (or continuously until stopped)
//                and reports done / aborted / cmd_err pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module triangle_seq_ctrl
  import triangle_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int CNT_W = c_def_cnt_w
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_peak,
  input  logic [WIDTH-1:0] cmd_step,
  input  logic [CNT_W-1:0] cmd_cycles,
  input  logic             stop,
  output logic [WIDTH-1:0] triangle,
  output logic             count_down,
  output logic             busy,
  output logic [CNT_W-1:0] periods_done,
  output logic             done,
  output logic             aborted,
  output logic             cmd_err
);

  state_t           r_state;
  logic [WIDTH-1:0] r_peak;
  logic [WIDTH-1:0] r_step;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_periods;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic             r_cmd_err;

  logic             w_idle;
  logic             w_bad_cmd;
  logic             w_start;
  logic             w_stop_run;
  logic             w_core_en;
  logic             w_core_clear;
  logic             w_wrap;
  logic [CNT_W-1:0] w_pd_next;
  logic             w_last;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_bad_cmd    = (cmd_peak == '0) || (cmd_step == '0);
  assign w_start      = w_idle && cmd_valid && !w_bad_cmd;
  assign w_stop_run   = (r_state == ST_RUN) && stop;
  // A stop freezes the wave and the period counter on the same edge
  assign w_core_en    = (r_state == ST_RUN) && !stop;
  assign w_core_clear = w_start || w_stop_run;
  assign w_pd_next    = r_periods + 1'b1;
  // cycles == 0 means continuous: never finish on a count
  assign w_last       = w_wrap && (r_cycles != '0) && (w_pd_next == r_cycles);

  assign cmd_ready    = w_idle;
  assign busy         = r_busy;
  assign periods_done = r_periods;
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign cmd_err      = r_cmd_err;

  triangle_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .en         (w_core_en),
    .clear      (w_core_clear),
    .peak       (r_peak),
    .step       (r_step),
    .triangle   (triangle),
    .count_down (count_down),
    .wrap       (w_wrap)
  );

  // Sequencer FSM: job latching, period counting and status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= c_rst_state;
      r_peak    <= '0;
      r_step    <= '0;
      r_cycles  <= '0;
      r_periods <= '0;
      r_busy    <= c_rst_flag;
      r_done    <= c_rst_flag;
      r_aborted <= c_rst_flag;
      r_cmd_err <= c_rst_flag;
    end else begin
      r_aborted <= 1'b0;
      r_cmd_err <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (w_bad_cmd) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_peak    <= cmd_peak;
              r_step    <= cmd_step;
              r_cycles  <= cmd_cycles;
              r_periods <= '0;
              r_busy    <= 1'b1;
              r_state   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_aborted <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (w_wrap) begin
            r_periods <= w_pd_next;
            if (w_last) begin
              r_state <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          // First FINISH cycle shows the final 0; the second carries done,
          // so cmd_ready rises the cycle after the done pulse.
          if (r_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_triangle_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_triangle_seq_ctrl
//  Description : Self-checking bench for triangle_seq_ctrl. Expected samples
//                come from a per-job period table built with plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_triangle_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_peak;
  logic [WIDTH-1:0] cmd_step;
  logic [CNT_W-1:0] cmd_cycles;
  logic             stop;
  logic [WIDTH-1:0] triangle;
  logic             count_down;
  logic             busy;
  logic [CNT_W-1:0] periods_done;
  logic             done;
  logic             aborted;
  logic             cmd_err;

  int n_checks = 0;
  int n_errors = 0;
  int last_pd  = 0;

  triangle_seq_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_peak     (cmd_peak),
    .cmd_step     (cmd_step),
    .cmd_cycles   (cmd_cycles),
    .stop         (stop),
    .triangle     (triangle),
    .count_down   (count_down),
    .busy         (busy),
    .periods_done (periods_done),
    .done         (done),
    .aborted      (aborted),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Status outputs while idle after a job, error or abort
  task automatic check_idle(input string tag);
    check_val({tag, "_tri"},   int'(triangle), 0);
    check_val({tag, "_cd"},    int'(count_down), 0);
    check_val({tag, "_busy"},  int'(busy), 0);
    check_val({tag, "_ready"}, int'(cmd_ready), 1);
    check_val({tag, "_pd"},    int'(periods_done), last_pd);
  endtask

  // Runs one job from an idle, posedge+1 position and checks every cycle.
  // stop_sel: -1 no stop, -2 random choice, >=0 RUN cycle index holding stop.
  task automatic run_job(input int pk, input int st, input int cyc,
                         input int stop_sel, input bit noise);
    int per[$];
    int up_n, v, len, total, stop_at, n;
    per.delete();
    v = 0;
    while (v < pk) begin per.push_back(v); v += st; end
    up_n = per.size();
    per.push_back(pk);
    v = pk - st;
    while (v > 0) begin per.push_back(v); v -= st; end
    len   = per.size();
    total = cyc * len;
    stop_at = stop_sel;
    if (stop_sel == -2) begin
      if (cyc == 0) stop_at = int'($urandom_range(0, 3 * len));
      else if ($urandom_range(0, 2) == 0) stop_at = int'($urandom_range(0, total - 1));
      else stop_at = -1;
    end
    if (cyc == 0 && stop_at < 0) stop_at = len;

    check_val("ready_before_job", int'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_peak   = WIDTH'(pk);
    cmd_step   = WIDTH'(st);
    cmd_cycles = CNT_W'(cyc);
    stop       = noise;  // stop is ignored in IDLE
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    stop      = 1'b0;

    for (n = 0; n < 20000; n++) begin
      if (cyc != 0 && n == total) break;
      check_val("run_tri",   int'(triangle), per[n % len]);
      check_val("run_cd",    int'(count_down), int'((n % len) >= up_n));
      check_val("run_busy",  int'(busy), 1);
      check_val("run_ready", int'(cmd_ready), 0);
      check_val("run_pd",    int'(periods_done), (n / len) % 256);
      check_val("run_done",  int'(done), 0);
      check_val("run_abort", int'(aborted), 0);
      check_val("run_err",   int'(cmd_err), 0);
      stop = (n == stop_at);
      if (noise) begin
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_peak   = WIDTH'($urandom_range(0, 255));
        cmd_step   = WIDTH'($urandom_range(0, 255));
        cmd_cycles = CNT_W'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (stop) begin
        stop    = 1'b0;
        last_pd = (n / len) % 256;
        check_val("abort_pulse", int'(aborted), 1);
        check_val("abort_nodone", int'(done), 0);
        check_idle("abort");
        @(posedge clk); #1;
        check_val("abort_one_cycle", int'(aborted), 0);
        check_idle("after_abort");
        return;
      end
    end

    if (!(cyc != 0 && n == total)) begin
      check_val("job_cycle_bound", n, total);
      return;
    end

    // Final 0 sample, wave not busy-released yet
    check_val("fin_tri",  int'(triangle), 0);
    check_val("fin_cd",   int'(count_down), 0);
    check_val("fin_busy", int'(busy), 1);
    check_val("fin_done", int'(done), 0);
    check_val("fin_pd",   int'(periods_done), cyc % 256);
    stop = noise;  // stop is ignored in FINISH
    @(posedge clk); #1;
    stop = 1'b0;
    check_val("done_pulse", int'(done), 1);
    check_val("done_busy",  int'(busy), 1);
    check_val("done_ready", int'(cmd_ready), 0);
    check_val("done_tri",   int'(triangle), 0);
    check_val("done_abort", int'(aborted), 0);
    @(posedge clk); #1;
    last_pd = cyc % 256;
    check_val("done_one_cycle", int'(done), 0);
    check_idle("after_done");
  endtask

  task automatic reject_job(input int pk, input int st);
    cmd_valid  = 1'b1;
    cmd_peak   = WIDTH'(pk);
    cmd_step   = WIDTH'(st);
    cmd_cycles = CNT_W'(2);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_val("err_pulse", int'(cmd_err), 1);
    check_idle("err");
    @(posedge clk); #1;
    check_val("err_one_cycle", int'(cmd_err), 0);
    check_idle("after_err");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pk, st, cyc;
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_peak   = '0;
    cmd_step   = '0;
    cmd_cycles = '0;
    stop       = 1'b0;
    #12;
    check_val("rst_done", int'(done), 0);
    check_val("rst_abort", int'(aborted), 0);
    check_val("rst_err", int'(cmd_err), 0);
    check_idle("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios
    run_job(4, 1, 1, -1, 1'b0);      // basic
    run_job(10, 3, 2, -1, 1'b0);     // non-divisible step
    run_job(2, 1, 0, 4, 1'b0);       // continuous, stop on 5th RUN cycle
    reject_job(0, 5);
    reject_job(7, 0);
    run_job(6, 2, 2, -1, 1'b1);      // blocked commands while busy
    run_job(5, 200, 3, -1, 1'b0);    // step larger than peak
    run_job(2, 1, 1, 3, 1'b0);       // stop coincident with final period

    // Asynchronous reset in the middle of a continuous job
    cmd_valid  = 1'b1;
    cmd_peak   = 8'd20;
    cmd_step   = 8'd1;
    cmd_cycles = 8'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    last_pd = 0;
    check_val("mid_rst_done", int'(done), 0);
    check_val("mid_rst_abort", int'(aborted), 0);
    check_idle("mid_rst");
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_abort", int'(aborted), 0);
    run_job(3, 1, 1, -1, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 20; j++) begin
      pk  = int'($urandom_range(1, 255));
      st  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 16))
                                         : int'($urandom_range(1, 255));
      cyc = int'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) reject_job(0, st);
      run_job(pk, st, cyc, -2, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/triangle_seq_ctrl.md
# triangle_seq_ctrl

Command-driven sequencer for the 8-bit triangle-wave datapath. It accepts a waveform job (peak, step, period count) over a valid/ready handshake and runs the up/down triangle generator for exactly that many periods, or continuously until stopped. It reports `done` or `aborted`, then returns the output to 0. It sits between the control logic and the triangle-wave consumer, replacing free-running generation with bounded, configurable bursts.

## Interface
- `WIDTH`, 8: sample, peak and step width.
- `CNT_W`, 8: period-count width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  job request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_peak`  in  WIDTH  turning point of the wave.
- `cmd_step`  in  WIDTH  increment/decrement per cycle.
- `cmd_cycles`  in  CNT_W  periods to run; 0 = continuous.
- `stop`  in  1  synchronous abort request.
- `triangle`  out  WIDTH  current sample.
- `count_down`  out  1  high while the wave is descending.
- `busy`  out  1  state != IDLE.
- `periods_done`  out  CNT_W  completed periods of current/last job.
- `done`  out  1  one-cycle pulse on normal completion.
- `aborted`  out  1  one-cycle pulse on stop.
- `cmd_err`  out  1  one-cycle pulse on a rejected job.

## Operation
- **States.** IDLE, RUN, FINISH.
- **Reset (`reset`=0).** State IDLE. `triangle`=0, `count_down`=0, `busy`=0, `periods_done`=0, `done`=`aborted`=`cmd_err`=0. `cmd_ready`=1.
- **IDLE.**
  - Accept on `cmd_valid && cmd_ready`; latch peak, step and cycles.
  - If `cmd_peak`==0 or `cmd_step`==0: pulse `cmd_err` next cycle and stay in IDLE.
  - Otherwise: go to RUN with `triangle`=0, `count_down`=0, `periods_done`=0.
- **RUN, ascending (`count_down`=0).**
  - Compute `triangle`+step in WIDTH+1 bits.
  - If the sum ≥ peak: `triangle`←peak, `count_down`←1.
  - Else: `triangle`←sum.
- **RUN, descending (`count_down`=1).**
  - If `triangle` ≤ step: `triangle`←0, `count_down`←0, `periods_done`+1 (wraps).
  - Else: `triangle`←`triangle`−step.
- **Period completion.** When a period completes and cycles≠0 and the new `periods_done`==cycles: go to FINISH.
- **FINISH.** `done`=1 for exactly one cycle, `triangle`=0, then IDLE.
- **Stop.**
  - `stop`=1 in RUN: next state IDLE, `triangle`←0, `count_down`←0, `aborted` pulses one cycle, `periods_done` frozen.
  - Stop on the same edge as the final period completing: stop wins; `aborted`, not `done`.
  - `stop` is ignored in IDLE and FINISH.
- **Blocked commands.** `cmd_valid` while busy is ignored; the command is not latched, and `cmd_ready`=0.
- **Step larger than peak.** The wave alternates 0, peak, 0 (period = 2 cycles).
- **Asynchronous reset mid-job.** Immediate return to reset values; no `done`/`aborted` pulse.

## Timing
- All outputs are registered. No combinational path from inputs to outputs except `cmd_ready` (a decode of state).
- Acceptance edge E0: `busy`=1 and `triangle`=0 from E0.
- First step appears at E1.
- Period length = 2·ceil(peak/step) cycles.
- `done` is high during the cycle after the final 0 sample. `cmd_ready` returns 1 one cycle later.
- A new job can be accepted on the edge `cmd_ready` is sampled high. Minimum gap between jobs: 1 IDLE cycle.
- `cmd_err` and `aborted` pulse in the cycle following the triggering edge.

## Structure
- **Shared package `triangle_pkg`:** state enum (IDLE, RUN, FINISH), `WIDTH`/`CNT_W` defaults, reset-value constants.
- **Sub-module `triangle_core`:**
  - Inputs: `clk`, `reset`, `en`, `clear`, `peak`, `step`.
  - Outputs: `triangle`, `count_down`, `wrap` (period-complete strobe).
  - Contains the up/down arithmetic.
- **`triangle_seq_ctrl` itself:** holds the FSM, job registers and period counter.

## Test plan
- **Basic run.** peak=4, step=1, cycles=1 → `triangle` 0,1,2,3,4,3,2,1,0; `count_down` high for samples 4..1; `done` one cycle; `periods_done`=1; `cmd_ready` back to 1.
- **Non-divisible step.** peak=10, step=3, cycles=2 → 0,3,6,9,10,7,4,1,0 repeated twice; `done` after the 2nd zero; `periods_done`=2.
- **Continuous mode with stop.** cycles=0, peak=2, step=1, hold `stop` at the 5th RUN cycle → `aborted` pulses, `triangle`=0, no `done`, `periods_done`=1.
- **Rejection and blocking.** peak=0 → `cmd_err` pulse, `busy` stays 0. Then step=0 → same. `cmd_valid` asserted while busy → ignored; the job completes with its original parameters.
- **Edge cases.** Step > peak (peak=5, step=200, cycles=3) → 0,5,0,5,0,5,0 then `done`. Stop coincident with the final period → `aborted` only.
- **Reset mid-run.** Assert `reset` low mid-run → all outputs at reset values immediately. After release, a new job is accepted on the first IDLE edge.
